// File: rtl/preset_digit_counter_pkg.sv
// Shared state encoding and helpers for the preset digit counter.
// Optional build macro: PRESET_DIGIT_COUNTER_UPDOWN_EN (adds decrement support).
package preset_digit_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Saturate a raw digit at the terminal value so preloads never hold an illegal code.
    function automatic int unsigned digit_clamp(input int unsigned value, input int unsigned dmax);
        return (value > dmax) ? dmax : value;
    endfunction

endpackage

// File: rtl/preset_digit_counter_digit_stage.sv
// One modulo digit of the cascaded counter: holds its value, computes its next value.
// Optional build macro: PRESET_DIGIT_COUNTER_UPDOWN_EN (adds the dir input and borrow path).
module digit_stage #(
    parameter int DIGIT_W   = 4,
    parameter int DIGIT_MAX = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_in,
    input  logic               count_en,
`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
    input  logic               dir,
`endif
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               terminal,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    always_comb begin
`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
        terminal = dir ? (digit == '0) : (digit == DMAX);
`else
        terminal = (digit == DMAX);
`endif
        wrap       = step_in && terminal;
        digit_next = digit;
        if (step_in) begin
`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
            if (dir)
                digit_next = terminal ? DMAX : digit - 1'b1;
            else
                digit_next = terminal ? '0 : digit + 1'b1;
`else
            digit_next = terminal ? '0 : digit + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (count_en)
            digit <= digit_next;
    end

endmodule

// File: rtl/preset_digit_counter.sv
// Cascaded modulo counter with preset target, run/hold FSM, terminal carry and done pulse.
// Optional build macro: PRESET_DIGIT_COUNTER_UPDOWN_EN (adds the down port).
module preset_digit_counter
    import preset_digit_counter_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int DIGIT_W   = 4,
    parameter int DIGIT_MAX = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      enable,
    input  logic                      set,
    input  logic [DIGITS*DIGIT_W-1:0] set_count,
    input  logic [DIGITS*DIGIT_W-1:0] target,
`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
    input  logic                      down,
`endif
    output logic [DIGITS*DIGIT_W-1:0] count,
    output logic                      carry_out,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    state_t                           state;
    logic [CW-1:0]                    target_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]   cur_d, next_d, load_d;
    logic [DIGITS:0]                  step;
    logic [DIGITS-1:0]                term, wrap;
    logic [CW-1:0]                    next_count;
    logic [DIGIT_W-1:0]               term_val;
    logic                             counting, load, all_term, hit, dir;

`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
    assign dir = down;
`else
    assign dir = 1'b0;
`endif

    assign counting   = (state == ST_RUN) && enable && !set && !start;
    assign load       = set || start;
    assign step[0]    = 1'b1;
    assign count      = cur_d;
    assign next_count = next_d;
    assign term_val   = dir ? '0 : DMAX;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            assign load_d[i] = set ? DIGIT_W'(digit_clamp(32'(set_count[i*DIGIT_W +: DIGIT_W]), DIGIT_MAX))
                                   : '0;
            digit_stage #(
                .DIGIT_W  (DIGIT_W),
                .DIGIT_MAX(DIGIT_MAX)
            ) u_digit (
                .clk       (clk),
                .reset     (reset),
                .step_in   (step[i]),
                .count_en  (counting),
`ifdef PRESET_DIGIT_COUNTER_UPDOWN_EN
                .dir       (dir),
`endif
                .load      (load),
                .load_val  (load_d[i]),
                .digit     (cur_d[i]),
                .digit_next(next_d[i]),
                .terminal  (term[i]),
                .wrap      (wrap[i])
            );
            assign step[i+1] = wrap[i];
        end
    endgenerate

    // Carry flags arrival at all-terminal; a whole-count wrap never lands there.
    always_comb begin
        all_term = !step[DIGITS];
        for (int d = 0; d < DIGITS; d++)
            if (next_d[d] != term_val)
                all_term = 1'b0;
    end

    assign hit = (target_q != '0) && (next_count == target_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            target_q  <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            done      <= 1'b0;
            if (set) begin
                // preload only; FSM and target untouched
            end else if (start) begin
                target_q <= target;
                state    <= ST_RUN;
                busy     <= 1'b1;
            end else if (counting) begin
                carry_out <= all_term;
                if (hit) begin
                    done  <= 1'b1;
                    state <= ST_HOLD;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule
